// File: rtl/idex_if.sv
// Decode-to-execute bundle for the ID/EX stage register.
// IDEX_PERF_EN adds the stall/bubble counter outputs.
interface idex_if #(
  parameter int XLEN    = 32,
  parameter int CTRL_W  = 9,
  parameter int NUM_FWD = 2
);
  logic                      stall;
  logic                      flush;
  logic                      in_valid;
  logic [CTRL_W-1:0]         ctrl_i;
  logic [31:0]               instr;
  logic [XLEN-1:0]           rs1_data;
  logic [XLEN-1:0]           rs2_data;
  logic [XLEN-1:0]           imm_i;
  logic [4:0]                rd_i;
  logic [NUM_FWD-1:0]        fwd_valid;
  logic [5*NUM_FWD-1:0]      fwd_rd;
  logic [XLEN*NUM_FWD-1:0]   fwd_data;

  logic                      out_valid;
  logic [CTRL_W-1:0]         ctrl_o;
  logic [XLEN-1:0]           rs1_data_o;
  logic [XLEN-1:0]           rs2_data_o;
  logic [4:0]                rs1_addr_o;
  logic [4:0]                rs2_addr_o;
  logic [XLEN-1:0]           imm_o;
  logic [2:0]                func3;
  logic [6:0]                func7;
  logic [4:0]                rd_o;
`ifdef IDEX_PERF_EN
  logic [31:0]               stall_cnt;
  logic [31:0]               bubble_cnt;
`endif

  modport master (
    output stall, flush, in_valid, ctrl_i, instr, rs1_data, rs2_data, imm_i, rd_i,
           fwd_valid, fwd_rd, fwd_data,
    input  out_valid, ctrl_o, rs1_data_o, rs2_data_o, rs1_addr_o, rs2_addr_o,
           imm_o, func3, func7, rd_o
`ifdef IDEX_PERF_EN
    , input stall_cnt, bubble_cnt
`endif
  );

  modport slave (
    input  stall, flush, in_valid, ctrl_i, instr, rs1_data, rs2_data, imm_i, rd_i,
           fwd_valid, fwd_rd, fwd_data,
    output out_valid, ctrl_o, rs1_data_o, rs2_data_o, rs1_addr_o, rs2_addr_o,
           imm_o, func3, func7, rd_o
`ifdef IDEX_PERF_EN
    , output stall_cnt, bubble_cnt
`endif
  );
endinterface

// File: rtl/idex_stage_reg.sv
// ID/EX pipeline register with internal operand bypass, stall-refresh and flush.
// Define IDEX_PERF_EN to add saturating stall/bubble counters.
module idex_fwd_sel #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2
) (
  input  logic [4:0]              addr,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [5*NUM_FWD-1:0]    fwd_rd,
  input  logic [XLEN*NUM_FWD-1:0] fwd_data,
  output logic                    hit,
  output logic [XLEN-1:0]         data
);
  // Walk from oldest to youngest so the lowest index overwrites last and wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int k = NUM_FWD-1; k >= 0; k--) begin
      if (fwd_valid[k] && fwd_rd[5*k +: 5] == addr && addr != 5'd0) begin
        hit  = 1'b1;
        data = fwd_data[XLEN*k +: XLEN];
      end
    end
  end
endmodule

module idex_stage_reg #(
  parameter int XLEN    = 32,
  parameter int CTRL_W  = 9,
  parameter int NUM_FWD = 2
) (
  input logic   clk,
  input logic   rst,
  idex_if.slave bus
);
  localparam int NSRC = 2;

  typedef struct packed {
    logic                       valid;
    logic [CTRL_W-1:0]          ctrl;
    logic [NSRC-1:0][XLEN-1:0]  opnd;
    logic [NSRC-1:0][4:0]       addr;
    logic [XLEN-1:0]            imm;
    logic [2:0]                 f3;
    logic [6:0]                 f7;
    logic [4:0]                 rd;
  } idex_q_t;

  idex_q_t q;

  logic [NSRC-1:0][4:0]      in_addr;
  logic [NSRC-1:0][4:0]      sel_addr;
  logic [NSRC-1:0][XLEN-1:0] rf_data;
  logic [NSRC-1:0]           fwd_hit;
  logic [NSRC-1:0][XLEN-1:0] fwd_val;
  logic [NSRC-1:0][XLEN-1:0] opnd_load;
  logic [NSRC-1:0][XLEN-1:0] opnd_hold;

  assign in_addr = {bus.instr[24:20], bus.instr[19:15]};
  assign rf_data = {bus.rs2_data, bus.rs1_data};

  // While stalled the bypass compares against the held addresses, not decode's.
  assign sel_addr = bus.stall ? q.addr : in_addr;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    idex_fwd_sel #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_sel (
      .addr      (sel_addr[i]),
      .fwd_valid (bus.fwd_valid),
      .fwd_rd    (bus.fwd_rd),
      .fwd_data  (bus.fwd_data),
      .hit       (fwd_hit[i]),
      .data      (fwd_val[i])
    );
    assign opnd_load[i] = (in_addr[i] == 5'd0) ? '0 :
                          fwd_hit[i]           ? fwd_val[i] : rf_data[i];
    assign opnd_hold[i] = fwd_hit[i] ? fwd_val[i] : q.opnd[i];
  end

  logic load_bubble;
  assign load_bubble = bus.flush || (!bus.stall && !bus.in_valid);

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load_bubble) begin
      q <= '0;
    end else if (bus.stall) begin
      q.opnd <= opnd_hold;
    end else begin
      q.valid <= 1'b1;
      q.ctrl  <= bus.ctrl_i;
      q.opnd  <= opnd_load;
      q.addr  <= in_addr;
      q.imm   <= bus.imm_i;
      q.f3    <= bus.instr[14:12];
      q.f7    <= bus.instr[31:25];
      q.rd    <= bus.rd_i;
    end
  end

  assign bus.out_valid  = q.valid;
  assign bus.ctrl_o     = q.ctrl;
  assign bus.rs1_data_o = q.opnd[0];
  assign bus.rs2_data_o = q.opnd[1];
  assign bus.rs1_addr_o = q.addr[0];
  assign bus.rs2_addr_o = q.addr[1];
  assign bus.imm_o      = q.imm;
  assign bus.func3      = q.f3;
  assign bus.func7      = q.f7;
  assign bus.rd_o       = q.rd;

  // Opcode and instr-rd bits are decoded upstream.
  logic unused_instr;
  assign unused_instr = ^bus.instr[11:0];

`ifdef IDEX_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] bubble_cnt_q;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (bus.stall && !bus.flush && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (load_bubble && bubble_cnt_q != '1)
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.bubble_cnt = bubble_cnt_q;
`endif
endmodule

// File: doc/idex_stage_reg.md
# idex_stage_reg

Parametrised ID/EX pipeline register for the MiniRiscV core. It sits between decode and execute and captures control, operands, immediate and destination each cycle. Operand bypass is resolved internally by comparing register addresses against NUM_FWD forwarding sources, so no precomputed select flags are needed. It supports stall (hold) and flush (bubble), and refreshes held operands from forwarding sources while stalled.

## Interface
- XLEN, 32, datapath width of operands, immediate and forwarded data
- CTRL_W, 9, width of packed control bundle {MemRead, MemtoReg, MemWrite, RegWrite, ALUSrc, ALUOp[3:0]}
- NUM_FWD, 2, number of forwarding sources; index 0 = youngest (EX), highest priority
- clk  in  1  clock; all state updates on falling edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold current contents (decode stalled)
- flush  in  1  load a bubble; overrides stall
- in_valid  in  1  decode slot holds a real instruction
- ctrl_i  in  CTRL_W  decoded control bundle
- instr  in  32  raw instruction; func3 = [14:12], func7 = [31:25], rs1 = [19:15], rs2 = [24:20]
- rs1_data, rs2_data  in  XLEN  register-file read data
- imm_i  in  XLEN  sign-extended immediate
- rd_i  in  5  destination register
- fwd_valid  in  NUM_FWD  source k will write fwd_data[k] to fwd_rd[k]
- fwd_rd  in  5*NUM_FWD  packed destination addresses, slice k = [5k+4:5k]
- fwd_data  in  XLEN*NUM_FWD  packed result data, slice k = [XLEN*k+XLEN-1:XLEN*k]
- out_valid  out  1  EX slot holds a real instruction
- ctrl_o  out  CTRL_W  registered control; all-zero when out_valid = 0
- rs1_data_o, rs2_data_o  out  XLEN  registered, bypass-resolved operands
- rs1_addr_o, rs2_addr_o  out  5  registered source addresses
- imm_o  out  XLEN;  func3  out  3;  func7  out  7;  rd_o  out  5

## Operation
- Operand select for each source (rs1, rs2) with address a: lowest k where fwd_valid[k] && fwd_rd[k] == a && a != 0 wins; otherwise register-file data. a = 0 always yields 0, regardless of rs*_data.
- Per falling edge, priority: rst > flush > stall > load.
- flush: out_valid, ctrl_o, imm_o, func3, func7, rd_o, rs*_addr_o, rs*_data_o all cleared to 0.
- stall (no flush): every field holds, except each operand is re-resolved against the held rs*_addr_o. If a forwarding source matches, the operand is overwritten with its data; otherwise it holds its value. It is never reloaded from rs*_data.
- load: out_valid <= in_valid. If in_valid = 0, all fields load as in a flush. Otherwise all fields load from inputs, with operands resolved against instr[19:15] and instr[24:20].
- rd_i = 0 with RegWrite set is passed through unchanged. Squashing is done downstream.

## Timing
- Latency 1 falling edge, input to output; outputs are pure register outputs.
- Forwarding inputs are combinational into the operand mux; they must be settled before the falling edge.
- rst asserted at any time, including mid-stall: all outputs go to 0 immediately. First capture happens on the first falling edge after deassertion.
- flush and stall in the same cycle: bubble inserted, stall ignored.
- Several sources matching the same address: lowest index wins. rs1 and rs2 with the same address each resolve to the same value.

## Configuration
- IDEX_PERF_EN defined: adds outputs stall_cnt and bubble_cnt (32 bits each, saturating at 2^32-1, reset to 0).
  - stall_cnt increments on each falling edge with stall && !flush.
  - bubble_cnt increments on each edge where a bubble is loaded (flush, or load with in_valid = 0).
- IDEX_PERF_EN undefined: neither port nor counter exists. Datapath behaviour is identical.

## Test plan
- Reset: rst = 1 mid-operation with out_valid = 1, ctrl_o = 9'h1FF -> all outputs 0 immediately, before any clock edge.
- Priority: rs1 = x5, fwd_rd = {x5, x5}, fwd_data = {0xBBBB, 0xAAAA} (k = 1, k = 0), fwd_valid = 2'b11 -> rs1_data_o = 0xAAAA. Same with fwd_valid = 2'b10 -> 0xBBBB.
- x0: rs2 = x0, fwd_rd[0] = 0, fwd_valid[0] = 1, fwd_data = 0x1234, rs2_data = 0x55 -> rs2_data_o = 0.
- Stall refresh: load rs1 = x7 with rs1_data = 0x10, then stall 3 cycles. Cycle 2 presents fwd_rd[1] = x7, fwd_data = 0x99 -> rs1_data_o = 0x99 after cycle 2 and still 0x99 after cycle 3. Other fields unchanged.
- Flush over stall: stall = flush = 1 with valid contents -> out_valid = 0, ctrl_o = 0, rs*_data_o = 0. With IDEX_PERF_EN: bubble_cnt +1, stall_cnt unchanged.
- Counter saturation (IDEX_PERF_EN): force stall_cnt = 0xFFFFFFFF, then stall one more cycle -> stall_cnt remains 0xFFFFFFFF.
